carregador_instrucoes: RTL
==========================

# carregador_instrucoes

Program loader that fills the instruction memory from a byte stream. It sits between a host or byte-serial front end and the write port of the writable instruction memory. It accepts a framed packet (start address, length, payload, checksum) over a valid/ready handshake and issues one registered write per payload byte. It reports completion and a checksum error.

## Interface

Parameters: none; address and data widths are fixed at 8 bits to match the 256 × 8 instruction memory.

- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- Iniciar  input  1  start pulse; sampled only in OCIOSO
- DadoEntrada  input  8  incoming stream byte
- ValidoEntrada  input  1  DadoEntrada valid
- ProntoEntrada  output  1  loader can accept a byte this cycle
- EnderecoEscrita  output  8  instruction-memory write address
- DadoEscrita  output  8  instruction-memory write data
- HabilitaEscrita  output  1  write strobe, one cycle per payload byte
- Ocupado  output  1  packet in progress
- Concluido  output  1  one-cycle pulse when the checksum byte is consumed
- Erro  output  1  checksum mismatch on the last packet; sticky

## Operation

- **Transfer rule:** a byte is consumed on a rising edge where ValidoEntrada && ProntoEntrada. One byte per cycle max; back-to-back transfers are allowed.
- **Packet format:** byte0 = start address A, byte1 = length L, then N payload bytes, then checksum C.
  - N = L, except L = 0 means N = 256.
  - Valid packet condition: (A + L + payload bytes + C) mod 256 == 0.
- **States:**
  - OCIOSO: ProntoEntrada = 0. Iniciar = 1 → ENDERECO, Ocupado ← 1, Erro ← 0, sum ← 0.
  - ENDERECO: on transfer, A is latched, sum += byte → TAMANHO.
  - TAMANHO: on transfer, remaining (9-bit) ← (byte == 0 ? 256 : byte), sum += byte → DADOS.
  - DADOS: on transfer, write issued at the current pointer, pointer ← pointer + 1 (mod 256, wraps 0xFF→0x00), sum += byte, remaining −= 1. When remaining reaches 0 → CHECKSUM.
  - CHECKSUM: on transfer, Concluido pulses, Erro ← ((sum + byte) mod 256 != 0), Ocupado ← 0 → OCIOSO.
- ProntoEntrada = 1 in ENDERECO, TAMANHO, DADOS and CHECKSUM.
- ValidoEntrada while not ready is ignored; the byte is not consumed.
- Iniciar outside OCIOSO is ignored.
- Payload writes are not rolled back on checksum error. Erro flags the memory contents as untrusted.
- Erro holds until the next accepted Iniciar or reset.
- All arithmetic is 8-bit modulo 256, except remaining, which is 9-bit.

## Timing

- **Reset:** all outputs 0 (ProntoEntrada, EnderecoEscrita, DadoEscrita, HabilitaEscrita, Ocupado, Concluido, Erro). State OCIOSO; internal sum, pointer and remaining are 0.
- **Reset mid-packet:** the packet is abandoned. No write strobe occurs in the cycle after reset is asserted.
- **Start latency:** Iniciar seen at edge k → ProntoEntrada = 1 and Ocupado = 1 after edge k.
- **Write latency:** payload byte consumed at edge k → HabilitaEscrita = 1 for exactly the cycle after edge k, with EnderecoEscrita/DadoEscrita valid in that cycle.
  - EnderecoEscrita/DadoEscrita hold their last value otherwise.
  - The memory latches on the rising edge ending that cycle.
- **Completion:** checksum consumed at edge k → Concluido = 1 and Erro updated for the cycle after edge k. ProntoEntrada = 0 in that same cycle.
- **Throughput:** a packet with N payload bytes and no stalls occupies N + 3 cycles of ProntoEntrada.
- **Fastest restart:** the earliest new Iniciar is accepted at the edge that ends the Concluido cycle.
- **Simultaneous reset and Iniciar:** reset wins.

## Test plan

- **Basic packet:** Iniciar, then 0x10, 0x03, 0x01, 0x02, 0x03, 0xE7 back-to-back → writes (0x10,0x01), (0x11,0x02), (0x12,0x03) on consecutive cycles; Concluido pulse; Erro = 0; memory reads back 01/02/03.
- **Address wrap:** 0xFE, 0x03, 0xAA, 0xBB, 0xCC, 0xCE → writes at 0xFE, 0xFF, 0x00; Erro = 0.
- **Bad checksum:** basic packet with checksum 0xE8 → the three writes still occur; Concluido pulses; Erro = 1 and stays 1 until the next Iniciar, then clears.
- **Length 0 = 256 writes:** A = 0x00, L = 0x00, bytes 0..255, correct checksum → exactly 256 strobes covering 0x00–0xFF; Erro = 0.
- **Stalls:** ValidoEntrada toggled randomly with a stable byte while low → identical writes and order to the unstalled run; no duplicate strobes.
- **Reset mid-payload:** reset after the 2nd payload byte → all outputs 0 next cycle with no further strobes; Iniciar ignored while not in OCIOSO.
  - A fresh basic packet afterwards completes correctly.

Source files
------------

// File: rtl/carregador_instrucoes_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// master = host/front end side, slave = loader side.
interface carregador_instrucoes_if;
   logic       Iniciar;
   logic [7:0] DadoEntrada;
   logic       ValidoEntrada;
   logic       ProntoEntrada;
   logic [7:0] EnderecoEscrita;
   logic [7:0] DadoEscrita;
   logic       HabilitaEscrita;
   logic       Ocupado;
   logic       Concluido;
   logic       Erro;

   modport master (
      output Iniciar, DadoEntrada, ValidoEntrada,
      input  ProntoEntrada, EnderecoEscrita, DadoEscrita, HabilitaEscrita,
             Ocupado, Concluido, Erro
   );

   modport slave (
      input  Iniciar, DadoEntrada, ValidoEntrada,
      output ProntoEntrada, EnderecoEscrita, DadoEscrita, HabilitaEscrita,
             Ocupado, Concluido, Erro
   );
endinterface

// File: rtl/carregador_instrucoes.sv
// Loads a framed packet (addr, len, payload, checksum) into instruction memory; one
// registered write the cycle after each payload byte; ProntoEntrada is 1 only while a packet is open.
module carregador_instrucoes (
   input  logic                   clock,
   input  logic                   reset,
   carregador_instrucoes_if.slave carga
);
   typedef enum logic [2:0] {
      OCIOSO,
      ENDERECO,
      TAMANHO,
      DADOS,
      CHECKSUM
   } estado_t;

   estado_t    estado;
   logic [7:0] soma;
   logic [7:0] ponteiro;
   logic [8:0] restante;

   logic       transferencia;
   logic [7:0] soma_prox;

   assign transferencia = carga.ValidoEntrada && carga.ProntoEntrada;
   assign soma_prox     = soma + carga.DadoEntrada;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado                <= OCIOSO;
         soma                  <= 8'd0;
         ponteiro              <= 8'd0;
         restante              <= 9'd0;
         carga.ProntoEntrada   <= 1'b0;
         carga.EnderecoEscrita <= 8'd0;
         carga.DadoEscrita     <= 8'd0;
         carga.HabilitaEscrita <= 1'b0;
         carga.Ocupado         <= 1'b0;
         carga.Concluido       <= 1'b0;
         carga.Erro            <= 1'b0;
      end else begin
         carga.HabilitaEscrita <= 1'b0;
         carga.Concluido       <= 1'b0;

         case (estado)
            OCIOSO: begin
               if (carga.Iniciar) begin
                  estado              <= ENDERECO;
                  soma                <= 8'd0;
                  carga.ProntoEntrada <= 1'b1;
                  carga.Ocupado       <= 1'b1;
                  carga.Erro          <= 1'b0;
               end
            end

            ENDERECO: begin
               if (transferencia) begin
                  ponteiro <= carga.DadoEntrada;
                  soma     <= soma_prox;
                  estado   <= TAMANHO;
               end
            end

            TAMANHO: begin
               if (transferencia) begin
                  // a zero length byte encodes a full 256-byte image
                  restante <= (carga.DadoEntrada == 8'd0) ? 9'd256 : {1'b0, carga.DadoEntrada};
                  soma     <= soma_prox;
                  estado   <= DADOS;
               end
            end

            DADOS: begin
               if (transferencia) begin
                  carga.EnderecoEscrita <= ponteiro;
                  carga.DadoEscrita     <= carga.DadoEntrada;
                  carga.HabilitaEscrita <= 1'b1;
                  ponteiro              <= ponteiro + 8'd1;
                  soma                  <= soma_prox;
                  restante              <= restante - 9'd1;
                  if (restante == 9'd1) begin
                     estado <= CHECKSUM;
                  end
               end
            end

            CHECKSUM: begin
               if (transferencia) begin
                  carga.Concluido     <= 1'b1;
                  carga.Erro          <= (soma_prox != 8'd0);
                  carga.Ocupado       <= 1'b0;
                  carga.ProntoEntrada <= 1'b0;
                  soma                <= soma_prox;
                  estado              <= OCIOSO;
               end
            end

            default: begin
               estado              <= OCIOSO;
               carga.ProntoEntrada <= 1'b0;
               carga.Ocupado       <= 1'b0;
            end
         endcase
      end
   end
endmodule
